// File: rtl/serial_logic_processor_if.sv
// serial_logic_processor_if.sv - control/data bundle between board I/O and the serial logic processor
//
// Groups the load/execute controls, operand data, function/routing selects and
// register/status outputs. master: drives controls (switches/buttons side).
// slave: the processor. OpCount exists only when LOGIC_PROC_OPCNT_EN is defined.
interface serial_logic_processor_if #(
    parameter int WIDTH   = 8,
    parameter int OPCNT_W = 8
);
    logic             LoadA;
    logic             LoadB;
    logic             Execute;
    logic [WIDTH-1:0] Din;
    logic [2:0]       F;
    logic [1:0]       R;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Busy;
    logic             Done;
`ifdef LOGIC_PROC_OPCNT_EN
    logic [OPCNT_W-1:0] OpCount;
`endif

    modport master (
        output LoadA, LoadB, Execute, Din, F, R,
`ifdef LOGIC_PROC_OPCNT_EN
        input  OpCount,
`endif
        input  Aval, Bval, Busy, Done
    );

    modport slave (
        input  LoadA, LoadB, Execute, Din, F, R,
`ifdef LOGIC_PROC_OPCNT_EN
        output OpCount,
`endif
        output Aval, Bval, Busy, Done
    );
endinterface

// File: rtl/serial_logic_processor.sv
// serial_logic_processor.sv - bit-serial 8-function logic unit over two WIDTH-bit registers
//
// Ports:
//   Clk    - system clock, all state on rising edge
//   Reset  - synchronous, active-low
//   bus    - serial_logic_processor_if.slave: LoadA/LoadB/Execute (active-low),
//            Din, F (function), R (routing), Aval/Bval, Busy, Done, [OpCount]
// Optional feature macro: LOGIC_PROC_OPCNT_EN (adds the OpCount completed-operation counter).
module serial_logic_processor #(
    parameter int WIDTH   = 8,
    parameter int OPCNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    serial_logic_processor_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       fq;
    logic [1:0]       rq;
    logic [CNT_W-1:0] count;
    logic             busy_q;
    logic             done_q;
    logic             fa;
`ifdef LOGIC_PROC_OPCNT_EN
    logic [OPCNT_W-1:0] opcnt_q;
    assign bus.OpCount = opcnt_q;
`endif

    // Function of the two LSBs under the function latched at start.
    always_comb begin
        fa = 1'b0;
        case (fq)
            3'b000:  fa = a_q[0] & b_q[0];
            3'b001:  fa = a_q[0] | b_q[0];
            3'b010:  fa = a_q[0] ^ b_q[0];
            3'b011:  fa = 1'b1;
            3'b100:  fa = ~(a_q[0] & b_q[0]);
            3'b101:  fa = ~(a_q[0] | b_q[0]);
            3'b110:  fa = ~(a_q[0] ^ b_q[0]);
            default: fa = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            fq     <= '0;
            rq     <= '0;
            count  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef LOGIC_PROC_OPCNT_EN
            opcnt_q <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // A load takes priority; Execute is simply sampled again next cycle.
                    if (!bus.LoadA || !bus.LoadB) begin
                        if (!bus.LoadA) a_q <= bus.Din;
                        if (!bus.LoadB) b_q <= bus.Din;
                    end else if (!bus.Execute) begin
                        fq     <= bus.F;
                        rq     <= bus.R;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Both registers rotate right; the new MSB is chosen by the latched routing.
                    a_q <= {(rq == 2'b10) ? fa : (rq == 2'b11) ? b_q[0] : a_q[0], a_q[WIDTH-1:1]};
                    b_q <= {(rq == 2'b01) ? fa : (rq == 2'b11) ? a_q[0] : b_q[0], b_q[WIDTH-1:1]};
                    if (count == LAST_CNT) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= HOLD;
`ifdef LOGIC_PROC_OPCNT_EN
                        opcnt_q <= opcnt_q + 1'b1;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                HOLD: begin
                    done_q <= 1'b0;
                    // Waiting for Execute release makes a held button yield one operation.
                    if (bus.Execute) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.Aval = a_q;
    assign bus.Bval = b_q;
    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
endmodule

// File: tb/tb_serial_logic_processor.sv
// tb/tb_serial_logic_processor.sv - directed self-checking bench for serial_logic_processor
module tb_serial_logic_processor;
    logic Clk = 1'b0;
    logic Reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   opcnt_exp = 0;

    always #5 Clk = ~Clk;

    serial_logic_processor_if #(.WIDTH(8),  .OPCNT_W(8)) b8 ();
    serial_logic_processor_if #(.WIDTH(16), .OPCNT_W(8)) b16 ();

    serial_logic_processor #(.WIDTH(8),  .OPCNT_W(8)) dut8  (.Clk(Clk), .Reset(Reset), .bus(b8));
    serial_logic_processor #(.WIDTH(16), .OPCNT_W(8)) dut16 (.Clk(Clk), .Reset(Reset), .bus(b16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load8(input logic [7:0] a, input logic [7:0] b);
        b8.Din = a; b8.LoadA = 1'b0; tick(); b8.LoadA = 1'b1;
        b8.Din = b; b8.LoadB = 1'b0; tick(); b8.LoadB = 1'b1;
    endtask

    // Runs one 8-bit operation with Execute held low for exec_n edges, then a
    // fixed tail so the unit is back in IDLE. Reports Busy samples, Done pulses
    // and the edge index (Execute edge = 1) at which Done was first seen.
    task automatic op8(input logic [2:0] f, input logic [1:0] r, input int exec_n,
                       output int busy_n, output int done_n, output int done_edge);
        int total;
        total = (exec_n + 2 > 12) ? exec_n + 2 : 12;
        busy_n = 0; done_n = 0; done_edge = 0;
        b8.F = f; b8.R = r; b8.Execute = 1'b0;
        for (int k = 1; k <= total; k++) begin
            tick();
            if (b8.Busy) busy_n++;
            if (b8.Done) begin
                done_n++;
                if (done_edge == 0) done_edge = k;
            end
            if (k >= exec_n) b8.Execute = 1'b1;
        end
        opcnt_exp = (opcnt_exp + 1) % 256;
    endtask

    initial begin
        int bn, dn, de;
        Reset = 1'b0;
        b8.LoadA = 1'b1; b8.LoadB = 1'b1; b8.Execute = 1'b1; b8.Din = '0; b8.F = '0; b8.R = '0;
        b16.LoadA = 1'b1; b16.LoadB = 1'b1; b16.Execute = 1'b1; b16.Din = '0; b16.F = '0; b16.R = '0;
        tick(); tick();
        check("rst_A", 32'(b8.Aval), 32'h0);
        check("rst_B", 32'(b8.Bval), 32'h0);
        check("rst_busy", 32'(b8.Busy), 32'h0);
        check("rst_done", 32'(b8.Done), 32'h0);
`ifdef LOGIC_PROC_OPCNT_EN
        check("rst_opcnt", 32'(b8.OpCount), 32'h0);
`endif
        Reset = 1'b1;

        // 1: XOR into A, Execute held 12 cycles
        load8(8'h33, 8'h55);
        check("load_A", 32'(b8.Aval), 32'h33);
        check("load_B", 32'(b8.Bval), 32'h55);
        op8(3'b010, 2'b10, 12, bn, dn, de);
        check("t1_A", 32'(b8.Aval), 32'h66);
        check("t1_B", 32'(b8.Bval), 32'h55);
        check("t1_done_cnt", 32'(dn), 32'd1);
        check("t1_done_edge", 32'(de), 32'd9);
        check("t1_busy_cnt", 32'(bn), 32'd8);

        // 2: XNOR into B, Execute pulsed one cycle
        op8(3'b110, 2'b01, 1, bn, dn, de);
        check("t2_A", 32'(b8.Aval), 32'h66);
        check("t2_B", 32'(b8.Bval), 32'hCC);
        check("t2_busy_cnt", 32'(bn), 32'd8);
        check("t2_done_cnt", 32'(dn), 32'd1);

        // 3: swap, then routing none
        op8(3'b000, 2'b11, 1, bn, dn, de);
        check("t3_swap_A", 32'(b8.Aval), 32'hCC);
        check("t3_swap_B", 32'(b8.Bval), 32'h66);
        op8(3'b011, 2'b00, 1, bn, dn, de);
        check("t3_none_A", 32'(b8.Aval), 32'hCC);
        check("t3_none_B", 32'(b8.Bval), 32'h66);

        // 4: AND into A; F/R changes and a LoadA during SHIFT must be ignored
        b8.F = 3'b000; b8.R = 2'b10; b8.Execute = 1'b0;
        tick();
        b8.Execute = 1'b1; b8.F = 3'b001; b8.R = 2'b01; b8.Din = 8'hFF; b8.LoadA = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        b8.LoadA = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        opcnt_exp++;
        check("t4_A", 32'(b8.Aval), 32'h44);
        check("t4_B", 32'(b8.Bval), 32'h66);
        check("t4_busy", 32'(b8.Busy), 32'h0);
`ifdef LOGIC_PROC_OPCNT_EN
        check("t4_opcnt", 32'(b8.OpCount), 32'(opcnt_exp));
`endif

        // 5: reset during SHIFT cycle 3
        b8.F = 3'b011; b8.R = 2'b10; b8.Execute = 1'b0;
        tick();
        b8.Execute = 1'b1;
        tick(); tick(); tick();
        check("t5_busy_pre", 32'(b8.Busy), 32'h1);
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        check("t5_A", 32'(b8.Aval), 32'h0);
        check("t5_B", 32'(b8.Bval), 32'h0);
        check("t5_busy", 32'(b8.Busy), 32'h0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (b8.Done || b8.Busy) dn++;
        end
        check("t5_no_activity", 32'(dn), 32'd0);
        opcnt_exp = 0;
`ifdef LOGIC_PROC_OPCNT_EN
        check("t5_opcnt", 32'(b8.OpCount), 32'h0);
`endif

        // Load and Execute on the same edge: load wins, Execute starts one edge later
        b8.Din = 8'h0F; b8.LoadA = 1'b0; b8.F = 3'b011; b8.R = 2'b10; b8.Execute = 1'b0;
        tick();
        b8.LoadA = 1'b1;
        check("lx_load_A", 32'(b8.Aval), 32'h0F);
        check("lx_not_busy", 32'(b8.Busy), 32'h0);
        tick();
        b8.Execute = 1'b1;
        check("lx_busy", 32'(b8.Busy), 32'h1);
        for (int k = 0; k < 10; k++) tick();
        opcnt_exp++;
        check("lx_A", 32'(b8.Aval), 32'hFF);
        check("lx_B", 32'(b8.Bval), 32'h00);

`ifdef LOGIC_PROC_OPCNT_EN
        while (opcnt_exp != 255) op8(3'b111, 2'b00, 1, bn, dn, de);
        check("opcnt_ff", 32'(b8.OpCount), 32'hFF);
        op8(3'b111, 2'b00, 1, bn, dn, de);
        check("opcnt_wrap", 32'(b8.OpCount), 32'h00);
`endif

        // 6: WIDTH=16 AND into A
        b16.Din = 16'hF0F0; b16.LoadA = 1'b0; tick(); b16.LoadA = 1'b1;
        b16.Din = 16'hFF00; b16.LoadB = 1'b0; tick(); b16.LoadB = 1'b1;
`ifdef LOGIC_PROC_OPCNT_EN
        check("t6_opcnt0", 32'(b16.OpCount), 32'h0);
`endif
        b16.F = 3'b000; b16.R = 2'b10; b16.Execute = 1'b0;
        bn = 0; dn = 0; de = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (b16.Busy) bn++;
            if (b16.Done) begin
                dn++;
                if (de == 0) de = k;
            end
            b16.Execute = 1'b1;
        end
        check("t6_A", 32'(b16.Aval), 32'hF000);
        check("t6_B", 32'(b16.Bval), 32'hFF00);
        check("t6_busy_cnt", 32'(bn), 32'd16);
        check("t6_done_edge", 32'(de), 32'd17);
        check("t6_done_cnt", 32'(dn), 32'd1);
`ifdef LOGIC_PROC_OPCNT_EN
        check("t6_opcnt1", 32'(b16.OpCount), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
